instruction_sequencer: RTL and testbench

- Fetch/decode/writeback control stage that sits directly upstream of the ALU and also consumes its result.
- Fetches instruction words from program memory over a req/valid handshake.
- Decodes opcode and two register indices, reads the internal register file, and drives opCode, accumulator, register0Value and register1Value into the ALU.
- Commits aluResult back into the accumulator, or commits the accumulator into the register file.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/register_file.sv | 40 ++++
 rtl/instruction_sequencer.sv | 142 ++++++++++++++
 tb/tb_instruction_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the instruction sequencer and the ALU.
//   - Default widths for the sequencer parameters.
//   - Opcode encodings. The ALU decodes the same values.
//   - FSM state enum.
//   - Instruction field offsets. The word layout is [opcode | r0 | r1], with
//     the opcode in the MSBs.
package cpu_pkg;

    localparam int DEFAULT_OPCODE_WIDTH   = 4;
    localparam int DEFAULT_REGISTER_WIDTH = 8;
    localparam int DEFAULT_REG_ADDR_WIDTH = 2;
    localparam int DEFAULT_PC_WIDTH       = 8;

    localparam int unsigned NOP0        = 0;
    localparam int unsigned ADD2        = 2;
    localparam int unsigned OR6         = 6;
    localparam int unsigned AND8        = 8;
    localparam int unsigned INCREMENT11 = 11;
    localparam int unsigned STORE12     = 12;
    localparam int unsigned LOAD13      = 13;
    localparam int unsigned HALT15      = 15;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    // Field offsets within the instruction word. The r1 field always sits
    // at bit 0.
    localparam int R1_LSB = 0;

    function automatic int r0_lsb(input int reg_addr_width);
        return reg_addr_width;
    endfunction

    function automatic int op_lsb(input int reg_addr_width);
        return 2 * reg_addr_width;
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file: small register file with two combinational read ports and
// one synchronous write port. An asynchronous reset clears every entry to 0.
// Ports:
//   clock, reset             - system clock and async active-high reset
//   write_enable/addr/data   - write port; the write lands on the rising edge
//   read0_addr/read0_data    - combinational read port 0
//   read1_addr/read1_data    - combinational read port 1
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read0_addr,
    output logic [DATA_WIDTH-1:0] read0_data,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    output logic [DATA_WIDTH-1:0] read1_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read0_data = regs[read0_addr];
    assign read1_data = regs[read1_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/writeback control stage in front of the
// ALU. It fetches instruction words, decodes them, presents the operands to
// the ALU, and commits the result.
// Ports:
//   clock, reset    - system clock and async active-high reset
//   imemAddr        - fetch address (always equal to the PC)
//   imemReq         - fetch request
//   imemValid       - imemData holds the word for imemAddr in this cycle
//   imemData        - instruction word [opcode | r0 | r1]
//   opCode          - opcode presented to the ALU (NOP0 outside DECODE/EXECUTE)
//   accumulator     - current accumulator
//   register0Value  - regfile[r0] of the latched instruction
//   register1Value  - regfile[r1] of the latched instruction
//   aluResult       - combinational ALU result
//   halted          - high while in HALT
//
// Fetch handshake: a word is accepted on a rising edge only when imemReq and
// imemValid are both high. imemReq is a register. It is low during reset and
// for the first cycle after reset, so an imemValid in that cycle is ignored.
// After every completed instruction the sequencer re-enters FETCH with imemReq
// already high, so memory with no wait states gives 3 cycles per instruction.
module instruction_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH   = DEFAULT_OPCODE_WIDTH,
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int PC_WIDTH       = DEFAULT_PC_WIDTH
) (
    input  logic                                   clock,
    input  logic                                   reset,
    output logic [PC_WIDTH-1:0]                    imemAddr,
    output logic                                   imemReq,
    input  logic                                   imemValid,
    input  logic [OPCODE_WIDTH+2*REG_ADDR_WIDTH-1:0] imemData,
    output logic [OPCODE_WIDTH-1:0]                opCode,
    output logic [REGISTER_WIDTH-1:0]              accumulator,
    output logic [REGISTER_WIDTH-1:0]              register0Value,
    output logic [REGISTER_WIDTH-1:0]              register1Value,
    input  logic [REGISTER_WIDTH-1:0]              aluResult,
    output logic                                   halted
);

    localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_ADDR_WIDTH;
    localparam int OP_LSB      = op_lsb(REG_ADDR_WIDTH);
    localparam int R0_LSB      = r0_lsb(REG_ADDR_WIDTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(NOP0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(ADD2);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(OR6);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(AND8);
    localparam logic [OPCODE_WIDTH-1:0] OP_INC   = OPCODE_WIDTH'(INCREMENT11);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(STORE12);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(LOAD13);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(HALT15);

    state_t                    state;
    logic [INSTR_WIDTH-1:0]    instr;
    logic [PC_WIDTH-1:0]       pc;

    logic [OPCODE_WIDTH-1:0]   ir_op;
    logic [REG_ADDR_WIDTH-1:0] ir_r0;
    logic [REG_ADDR_WIDTH-1:0] ir_r1;
    logic                      store_commit;

    assign ir_op = instr[OP_LSB +: OPCODE_WIDTH];
    assign ir_r0 = instr[R0_LSB +: REG_ADDR_WIDTH];
    assign ir_r1 = instr[R1_LSB +: REG_ADDR_WIDTH];

    assign imemAddr = pc;

    // STORE writes on the EXECUTE edge. The next instruction's DECODE comes
    // at least two cycles later and sees the new value.
    assign store_commit = (state == EXECUTE) && (ir_op == OP_STORE);

    register_file #(
        .DATA_WIDTH (REGISTER_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_register_file (
        .clock        (clock),
        .reset        (reset),
        .write_enable (store_commit),
        .write_addr   (ir_r0),
        .write_data   (accumulator),
        .read0_addr   (ir_r0),
        .read0_data   (register0Value),
        .read1_addr   (ir_r1),
        .read1_data   (register1Value)
    );

    // opCode, imemReq and halted are registers. They are set one edge ahead
    // of the state they belong to, so no input reaches them combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= '0;
            accumulator <= '0;
            instr       <= '0;
            opCode      <= OP_NOP;
            imemReq     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    imemReq <= 1'b1;
                    if (imemReq && imemValid) begin
                        instr   <= imemData;
                        opCode  <= imemData[OP_LSB +: OPCODE_WIDTH];
                        imemReq <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    // Operands settle for a full cycle before the commit.
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    opCode <= OP_NOP;
                    case (ir_op)
                        OP_ADD, OP_INC, OP_AND, OP_OR: accumulator <= aluResult;
                        OP_LOAD:                       accumulator <= register0Value;
                        default: ;
                    endcase
                    if (ir_op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        pc      <= pc + PC_WIDTH'(1);
                        imemReq <= 1'b1;
                        state   <= FETCH;
                    end
                end
                HALT: begin
                    // Only reset leaves this state.
                    state <= HALT;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;
    import cpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] imemAddr;
    logic       imemReq;
    logic       imemValid = 1'b0;
    logic [7:0] imemData = 8'h00;
    logic [3:0] opCode;
    logic [7:0] accumulator;
    logic [7:0] register0Value;
    logic [7:0] register1Value;
    logic [7:0] aluResult;
    logic       halted;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] model_pc = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] instr;
        int         waits;
        logic [7:0] acc;
        logic [7:0] r0v;
        logic [7:0] r1v;
    } vec_t;

    vec_t vecs[17];

    instruction_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .imemAddr       (imemAddr),
        .imemReq        (imemReq),
        .imemValid      (imemValid),
        .imemData       (imemData),
        .opCode         (opCode),
        .accumulator    (accumulator),
        .register0Value (register0Value),
        .register1Value (register1Value),
        .aluResult      (aluResult),
        .halted         (halted)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural ALU feeding the sequencer
    always_comb begin
        aluResult = 8'h00;
        case (opCode)
            4'(ADD2):        aluResult = register0Value + register1Value;
            4'(INCREMENT11): aluResult = accumulator + 8'd1;
            4'(AND8):        aluResult = register0Value & register1Value;
            4'(OR6):         aluResult = register0Value | register1Value;
            default:         aluResult = 8'h00;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Assert reset at a falling edge, check the outputs while it is held,
    // then release at a falling edge.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        imemValid = 1'b0;
        #1;
        check("rst_imemReq", imemReq, 0);
        check("rst_halted", halted, 0);
        check("rst_opCode", opCode, 0);
        check("rst_acc", accumulator, 0);
        check("rst_imemAddr", imemAddr, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_pc = 8'h00;
    endtask

    // First cycle after reset: imemReq is low and a valid word must be ignored.
    task automatic post_reset();
        check("post_rst_req_low", imemReq, 0);
        imemValid = 1'b1;
        imemData = 8'hB0;
        @(negedge clock);
        imemValid = 1'b0;
        check("post_rst_req_high", imemReq, 1);
        check("post_rst_opCode", opCode, 0);
        check("post_rst_acc", accumulator, 0);
        check("post_rst_addr", imemAddr, 0);
    endtask

    // Run one instruction. Entry and exit are at a falling edge with the
    // DUT in FETCH and imemReq high.
    task automatic exec(input logic [7:0] instr, input int waits, input logic [7:0] acc,
                        input logic [7:0] r0v, input logic [7:0] r1v);
        int         start;
        logic [7:0] acc_before;
        logic [7:0] exp;
        start = cyc;
        acc_before = accumulator;
        for (int w = 0; w < waits; w++) begin
            check("wait_req", imemReq, 1);
            check("wait_addr", imemAddr, model_pc);
            check("wait_acc", accumulator, acc_before);
            check("wait_opCode", opCode, 0);
            imemValid = 1'b0;
            imemData = 8'($urandom_range(0, 255));
            @(negedge clock);
        end
        check("fetch_req", imemReq, 1);
        check("fetch_addr", imemAddr, model_pc);
        check("fetch_opCode", opCode, 0);
        imemValid = 1'b1;
        imemData = instr;
        exp_q.push_back(acc);
        @(negedge clock);
        imemValid = 1'b0;
        imemData = 8'($urandom_range(0, 255));
        check("decode_req", imemReq, 0);
        check("decode_opCode", opCode, {28'd0, instr[7:4]});
        check("decode_r0", register0Value, r0v);
        check("decode_r1", register1Value, r1v);
        @(negedge clock);
        check("execute_opCode", opCode, {28'd0, instr[7:4]});
        check("execute_r0", register0Value, r0v);
        check("execute_r1", register1Value, r1v);
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check("commit_acc", accumulator, exp);
        end
        if (instr[7:4] == 4'(HALT15)) begin
            check("halt_flag", halted, 1);
            check("halt_req", imemReq, 0);
            check("halt_addr", imemAddr, model_pc);
            check("halt_opCode", opCode, 0);
        end else begin
            model_pc = model_pc + 8'd1;
            check("next_addr", imemAddr, model_pc);
            check("next_req", imemReq, 1);
            check("next_halted", halted, 0);
            check("cycles_per_instr", cyc - start, waits + 3);
        end
    endtask

    initial begin
        // instr, waits, accumulator after, register0Value, register1Value
        vecs[0]  = '{8'hB0, 0, 8'd1,  8'd0, 8'd0};
        vecs[1]  = '{8'hB0, 0, 8'd2,  8'd0, 8'd0};
        vecs[2]  = '{8'hB0, 0, 8'd3,  8'd0, 8'd0};
        vecs[3]  = '{8'hB0, 0, 8'd4,  8'd0, 8'd0};
        vecs[4]  = '{8'hB0, 0, 8'd5,  8'd0, 8'd0};
        vecs[5]  = '{8'hC8, 0, 8'd5,  8'd0, 8'd0};  // STORE r2
        vecs[6]  = '{8'hB0, 0, 8'd6,  8'd0, 8'd0};
        vecs[7]  = '{8'hC4, 0, 8'd6,  8'd0, 8'd0};  // STORE r1
        vecs[8]  = '{8'h26, 0, 8'd11, 8'd6, 8'd5};  // ADD r1,r2
        vecs[9]  = '{8'h86, 0, 8'd4,  8'd6, 8'd5};  // AND r1,r2
        vecs[10] = '{8'h66, 0, 8'd7,  8'd6, 8'd5};  // OR r1,r2
        vecs[11] = '{8'hD8, 0, 8'd5,  8'd5, 8'd0};  // LOAD r2
        vecs[12] = '{8'h00, 0, 8'd5,  8'd0, 8'd0};  // NOP
        vecs[13] = '{8'h30, 0, 8'd5,  8'd0, 8'd0};  // undefined opcode 3
        vecs[14] = '{8'hB9, 4, 8'd6,  8'd5, 8'd6};  // INC with 4 wait cycles
        vecs[15] = '{8'hC0, 0, 8'd6,  8'd0, 8'd0};  // STORE r0
        vecs[16] = '{8'h24, 0, 8'd12, 8'd6, 8'd6};  // ADD r0,r1 sees new r0

        // Table-driven program
        apply_reset();
        post_reset();
        for (int i = 0; i < 17; i++) begin
            exec(vecs[i].instr, vecs[i].waits, vecs[i].acc, vecs[i].r0v, vecs[i].r1v);
        end

        // Accumulator and PC wrap
        apply_reset();
        post_reset();
        for (int i = 0; i < 255; i++) begin
            exec(8'hB0, 0, 8'(i + 1), 8'd0, 8'd0);
        end
        check("pc_at_ff", imemAddr, 8'hFF);
        exec(8'h00, 0, 8'hFF, 8'd0, 8'd0);
        check("pc_wrap", imemAddr, 8'h00);
        exec(8'hB0, 0, 8'h00, 8'd0, 8'd0);

        // HALT at address 4
        apply_reset();
        post_reset();
        for (int i = 0; i < 4; i++) exec(8'h00, 0, 8'd0, 8'd0, 8'd0);
        exec(8'hF0, 0, 8'd0, 8'd0, 8'd0);
        check("halt_at_4", imemAddr, 8'd4);
        for (int i = 0; i < 3; i++) begin
            imemValid = 1'b1;
            imemData = 8'hB0;
            @(negedge clock);
            check("halt_stay", halted, 1);
            check("halt_stay_req", imemReq, 0);
            check("halt_stay_addr", imemAddr, 8'd4);
            check("halt_stay_acc", accumulator, 0);
        end
        imemValid = 1'b0;
        apply_reset();
        post_reset();

        // Reset during DECODE of ADD r1,r2
        exec(8'hB0, 0, 8'd1, 8'd0, 8'd0);
        exec(8'hC4, 0, 8'd1, 8'd0, 8'd0);
        exec(8'hB0, 0, 8'd2, 8'd0, 8'd0);
        exec(8'hC8, 0, 8'd2, 8'd0, 8'd0);
        imemValid = 1'b1;
        imemData = 8'h26;
        @(negedge clock);
        imemValid = 1'b0;
        check("abort_decode_op", opCode, 2);
        check("abort_decode_r0", register0Value, 1);
        check("abort_decode_r1", register1Value, 2);
        #2;
        reset = 1'b1;
        #1;
        check("abort_acc", accumulator, 0);
        check("abort_opCode", opCode, 0);
        check("abort_req", imemReq, 0);
        check("abort_addr", imemAddr, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_pc = 8'h00;
        post_reset();
        exec(8'h26, 0, 8'd0, 8'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
